perf_counter_unit: RTL and testbench
====================================

PERF_COUNTER_UNIT -- requirements
Module: perf_counter_unit

Interface
REQ-001 SHALL have parameter NUM_EVENTS, default 4: number of event counter channels (1..16).
REQ-002 SHALL have parameter CNT_WIDTH, default 32: width of every counter (8..64).
REQ-003 SHALL have parameter MAX_CLOCKS, default 4096: cycle limit in RUN that forces a timeout.
REQ-004 SHALL have parameter SATURATE, default 1: 1 = counters hold at all-ones, 0 = counters wrap to 0.
REQ-005 SHALL have one clock and an asynchronous active-low reset, as follows.
REQ-006 SHALL have port input_clk  input  1  clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous reset, active-low.
REQ-008 SHALL have port start  input  1  begin or restart a measurement run.
REQ-009 SHALL have port halt  input  1  program end (hlt retired); ends the run.
REQ-010 SHALL have port clear  input  1  synchronous clear of all counters and flags; returns to IDLE.
REQ-011 SHALL have port event_in  input  NUM_EVENTS  per-channel increment strobes (stall, branch predicted, branch missed, ...).
REQ-012 SHALL have port snap  input  1  copy all live counters into shadow registers.
REQ-013 SHALL have port rd_sel  input  max(1,clog2(NUM_EVENTS))  shadow channel select.
REQ-014 SHALL have port rd_data  output  CNT_WIDTH  registered shadow value of the selected channel.
REQ-015 SHALL have port cycles_consumed  output  CNT_WIDTH  live cycle counter.
REQ-016 SHALL have port running  output  1  high in RUN.
REQ-017 SHALL have port done  output  1  high in DONE.
REQ-018 SHALL have port timeout  output  1  sticky; the run ended by MAX_CLOCKS.
REQ-019 SHALL have port overflow  output  NUM_EVENTS  sticky per-channel overflow flags.

Function
REQ-020 SHALL implement FSM states IDLE, RUN, DONE; reset state is IDLE.
REQ-021 IDLE: counters hold; start=1 SHALL move to RUN on the next edge.
REQ-022 RUN: cycles_consumed SHALL increment by 1 every cycle, including the cycle in which halt is sampled, so the hlt cycle is counted without software correction.
REQ-023 RUN: channel i SHALL increment by 1 on each edge where event_in[i]=1; event_in SHALL be ignored outside RUN.
REQ-024 RUN -> DONE SHALL occur on the edge where halt=1.
REQ-025 RUN -> DONE SHALL occur on the edge where cycles_consumed reaches MAX_CLOCKS (post-increment value == MAX_CLOCKS), setting timeout=1; a simultaneous halt SHALL also end the run, and timeout SHALL still be set.
REQ-026 DONE: all counters SHALL freeze; start=1 SHALL zero all counters, overflow and timeout, and enter RUN on the same edge.
REQ-027 Priority SHALL be clear > halt/timeout > start; clear in any state zeroes all counters, shadows, flags and goes to IDLE.
REQ-028 A counter at all-ones receiving an increment SHALL set its overflow bit (cycle counter included in timeout logic only) and then hold (SATURATE=1) or wrap to 0 (SATURATE=0).
REQ-029 snap=1 SHALL load every shadow with the live counter value before that edge's increment; snap is honoured in any state.
REQ-030 rd_data SHALL equal shadow[rd_sel] one cycle after rd_sel is applied; rd_sel >= NUM_EVENTS SHALL return 0.
REQ-031 running and done SHALL be registered, decoded directly from the state register.

Reset
REQ-032 rst=0 SHALL immediately, regardless of clock, force state IDLE and cycles_consumed, all channel counters, shadows, rd_data, overflow, timeout, running and done to 0.
REQ-033 A rst assertion mid-RUN SHALL discard the run; after release the block SHALL wait in IDLE for start.
REQ-034 Release of rst SHALL be sampled synchronously; no counting on the release edge unless start is also high.

Verification
REQ-035 rst released, start pulsed, 10 idle cycles, halt on cycle 11 -> done=1, cycles_consumed=11, all channels 0.
REQ-036 RUN with event_in=4'b0101 for 5 cycles then halt -> channels 0,2 = 5 (after snap, rd_sel=0/2 give 5), channels 1,3 = 0.
REQ-037 MAX_CLOCKS=16, no halt -> DONE after 16 RUN cycles, cycles_consumed=16, timeout=1, counters frozen thereafter.
REQ-038 CNT_WIDTH=8, event_in[0] held 300 cycles: SATURATE=1 -> channel 0 = 255, overflow[0]=1; SATURATE=0 -> channel 0 = 44, overflow[0]=1.
REQ-039 snap and event_in[1] same edge with channel 1 = 7 -> shadow 7, live 8; clear and halt same edge -> IDLE, all zero.
REQ-040 rst=0 asserted mid-RUN between clock edges -> all outputs 0 immediately; start after release -> fresh count from 0.

Source files
------------

// File: rtl/perf_counter_if.sv
// Bundles the control strobes, event inputs and readback/status outputs of perf_counter_unit.
interface perf_counter_if #(
  parameter int NUM_EVENTS = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int SEL_W      = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1
);
  logic                  start;
  logic                  halt;
  logic                  clear;
  logic                  snap;
  logic [NUM_EVENTS-1:0] event_in;
  logic [SEL_W-1:0]      rd_sel;
  logic [CNT_WIDTH-1:0]  rd_data;
  logic [CNT_WIDTH-1:0]  cycles_consumed;
  logic                  running;
  logic                  done;
  logic                  timeout;
  logic [NUM_EVENTS-1:0] overflow;

  modport master (
    output start, halt, clear, snap, event_in, rd_sel,
    input  rd_data, cycles_consumed, running, done, timeout, overflow
  );

  modport slave (
    input  start, halt, clear, snap, event_in, rd_sel,
    output rd_data, cycles_consumed, running, done, timeout, overflow
  );
endinterface

// File: rtl/perf_counter_unit.sv
// Performance counter block: a cycle counter plus NUM_EVENTS event counters
// measured over one run, with snapshot shadows for readback.
module perf_counter_unit #(
  parameter int NUM_EVENTS = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int MAX_CLOCKS = 4096,
  parameter int SATURATE   = 1
) (
  input  logic          input_clk,
  input  logic          rst,
  perf_counter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [63:0] MAX_L = 64'(MAX_CLOCKS);

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cyc_q, cyc_d, cyc_inc;
  logic [CNT_WIDTH-1:0]  cnt_q    [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  cnt_d    [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  shadow_q [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  shadow_d [NUM_EVENTS];
  logic [NUM_EVENTS-1:0] ovf_q, ovf_d;
  logic                  timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic                  running_q, running_d;
  logic                  done_q, done_d;
  logic                  timeout_hit;
  logic                  restart;

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    ovf_d     = ovf_q;
    timeout_d = timeout_q;
    restart   = 1'b0;

    if (&cyc_q) begin
      cyc_inc = (SATURATE != 0) ? cyc_q : '0;
    end else begin
      cyc_inc = cyc_q + CNT_WIDTH'(1);
    end
    timeout_hit = (state_q == RUN) && (64'(cyc_inc) == MAX_L);

    // Shadows capture the pre-increment values of this edge.
    if (bus.snap) begin
      shadow_d = cnt_q;
    end

    rd_data_d = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (int'(bus.rd_sel) == i) begin
        rd_data_d = shadow_q[i];
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          restart = 1'b1;
        end
      end
      RUN: begin
        cyc_d = cyc_inc;
        for (int i = 0; i < NUM_EVENTS; i++) begin
          if (bus.event_in[i]) begin
            if (&cnt_q[i]) begin
              ovf_d[i] = 1'b1;
              cnt_d[i] = (SATURATE != 0) ? cnt_q[i] : '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
          end
        end
        if (bus.halt || timeout_hit) begin
          state_d = DONE;
        end
        if (timeout_hit) begin
          timeout_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_d = RUN;
          restart = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (restart) begin
      cyc_d     = '0;
      cnt_d     = '{default: '0};
      ovf_d     = '0;
      timeout_d = 1'b0;
    end

    // Clear overrides everything else, including a same-edge halt or snap.
    if (bus.clear) begin
      state_d   = IDLE;
      cyc_d     = '0;
      cnt_d     = '{default: '0};
      shadow_d  = '{default: '0};
      ovf_d     = '0;
      timeout_d = 1'b0;
      rd_data_d = '0;
    end

    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge input_clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      cnt_q     <= '{default: '0};
      shadow_q  <= '{default: '0};
      ovf_q     <= '0;
      timeout_q <= 1'b0;
      rd_data_q <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      ovf_q     <= ovf_d;
      timeout_q <= timeout_d;
      rd_data_q <= rd_data_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign bus.rd_data         = rd_data_q;
  assign bus.cycles_consumed = cyc_q;
  assign bus.running         = running_q;
  assign bus.done            = done_q;
  assign bus.timeout         = timeout_q;
  assign bus.overflow        = ovf_q;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Directed bench for perf_counter_unit: default, short-timeout, 8-bit saturating
// and 8-bit wrapping instances share one clock and reset.
module tb_perf_counter_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  perf_counter_if #(.NUM_EVENTS(4), .CNT_WIDTH(32)) if0 ();
  perf_counter_if #(.NUM_EVENTS(4), .CNT_WIDTH(32)) ift ();
  perf_counter_if #(.NUM_EVENTS(3), .CNT_WIDTH(8))  ifs ();
  perf_counter_if #(.NUM_EVENTS(3), .CNT_WIDTH(8))  ifw ();

  perf_counter_unit #(.NUM_EVENTS(4), .CNT_WIDTH(32), .MAX_CLOCKS(4096), .SATURATE(1))
    u_dut (.input_clk(clk), .rst(rst), .bus(if0));
  perf_counter_unit #(.NUM_EVENTS(4), .CNT_WIDTH(32), .MAX_CLOCKS(16), .SATURATE(1))
    u_to (.input_clk(clk), .rst(rst), .bus(ift));
  perf_counter_unit #(.NUM_EVENTS(3), .CNT_WIDTH(8), .MAX_CLOCKS(4096), .SATURATE(1))
    u_sat (.input_clk(clk), .rst(rst), .bus(ifs));
  perf_counter_unit #(.NUM_EVENTS(3), .CNT_WIDTH(8), .MAX_CLOCKS(4096), .SATURATE(0))
    u_wrap (.input_clk(clk), .rst(rst), .bus(ifw));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    step(1);
    checks++; if (if0.cycles_consumed !== 32'd0) begin errors++; $display("[TB] FAIL reset_cycles got %0d want 0", if0.cycles_consumed); end
    checks++; if ({if0.running, if0.done, if0.timeout} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got %b want 000", {if0.running, if0.done, if0.timeout}); end
    checks++; if (if0.overflow !== 4'd0 || if0.rd_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_ovf_rd got %h/%0d want 0/0", if0.overflow, if0.rd_data); end
    rst = 1'b1;
    step(2);
    checks++; if (if0.running !== 1'b0 || if0.cycles_consumed !== 32'd0) begin errors++; $display("[TB] FAIL idle_after_release got run=%b cyc=%0d want 0/0", if0.running, if0.cycles_consumed); end
  endtask

  task automatic test_basic_run();
    if0.start = 1'b1; step(1); if0.start = 1'b0;
    checks++; if (if0.running !== 1'b1 || if0.cycles_consumed !== 32'd0) begin errors++; $display("[TB] FAIL start_edge got run=%b cyc=%0d want 1/0", if0.running, if0.cycles_consumed); end
    step(10);
    checks++; if (if0.cycles_consumed !== 32'd10) begin errors++; $display("[TB] FAIL run10_cycles got %0d want 10", if0.cycles_consumed); end
    if0.halt = 1'b1; step(1); if0.halt = 1'b0;
    checks++; if (if0.done !== 1'b1 || if0.running !== 1'b0) begin errors++; $display("[TB] FAIL halt_state got done=%b run=%b want 1/0", if0.done, if0.running); end
    checks++; if (if0.cycles_consumed !== 32'd11) begin errors++; $display("[TB] FAIL halt_cycles got %0d want 11", if0.cycles_consumed); end
    step(3);
    checks++; if (if0.cycles_consumed !== 32'd11) begin errors++; $display("[TB] FAIL done_frozen got %0d want 11", if0.cycles_consumed); end
    if0.snap = 1'b1; step(1); if0.snap = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if0.rd_sel = 2'(i); step(1);
      checks++; if (if0.rd_data !== 32'd0) begin errors++; $display("[TB] FAIL idle_channel%0d got %0d want 0", i, if0.rd_data); end
    end
  endtask

  task automatic test_events();
    int exp_ev[4];
    exp_ev = '{5, 0, 5, 0};
    if0.start = 1'b1; step(1); if0.start = 1'b0;
    checks++; if (if0.cycles_consumed !== 32'd0 || if0.running !== 1'b1) begin errors++; $display("[TB] FAIL restart got cyc=%0d run=%b want 0/1", if0.cycles_consumed, if0.running); end
    if0.event_in = 4'b0101; step(5); if0.event_in = 4'b0000;
    if0.halt = 1'b1; step(1); if0.halt = 1'b0;
    checks++; if (if0.cycles_consumed !== 32'd6) begin errors++; $display("[TB] FAIL events_cycles got %0d want 6", if0.cycles_consumed); end
    // Events while DONE must be ignored.
    if0.event_in = 4'b1111; step(2); if0.event_in = 4'b0000;
    if0.snap = 1'b1; step(1); if0.snap = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if0.rd_sel = 2'(i); step(1);
      checks++; if (if0.rd_data !== 32'(exp_ev[i])) begin errors++; $display("[TB] FAIL event_channel%0d got %0d want %0d", i, if0.rd_data, exp_ev[i]); end
    end
  endtask

  task automatic test_snap_same_edge();
    if0.start = 1'b1; step(1); if0.start = 1'b0;
    if0.event_in = 4'b0010; step(7);
    if0.snap = 1'b1; step(1); if0.snap = 1'b0; if0.event_in = 4'b0000;
    if0.rd_sel = 2'd1; step(1);
    checks++; if (if0.rd_data !== 32'd7) begin errors++; $display("[TB] FAIL snap_pre_increment got %0d want 7", if0.rd_data); end
    if0.halt = 1'b1; step(1); if0.halt = 1'b0;
    if0.snap = 1'b1; step(1); if0.snap = 1'b0;
    step(1);
    checks++; if (if0.rd_data !== 32'd8) begin errors++; $display("[TB] FAIL snap_live got %0d want 8", if0.rd_data); end
  endtask

  task automatic test_clear_halt();
    if0.start = 1'b1; step(1); if0.start = 1'b0;
    if0.event_in = 4'b0001; step(3); if0.event_in = 4'b0000;
    if0.snap = 1'b1; step(1); if0.snap = 1'b0;
    if0.clear = 1'b1; if0.halt = 1'b1; step(1); if0.clear = 1'b0; if0.halt = 1'b0;
    checks++; if ({if0.running, if0.done, if0.timeout} !== 3'b000) begin errors++; $display("[TB] FAIL clear_flags got %b want 000", {if0.running, if0.done, if0.timeout}); end
    checks++; if (if0.cycles_consumed !== 32'd0 || if0.rd_data !== 32'd0) begin errors++; $display("[TB] FAIL clear_values got cyc=%0d rd=%0d want 0/0", if0.cycles_consumed, if0.rd_data); end
    if0.rd_sel = 2'd0; step(1);
    checks++; if (if0.rd_data !== 32'd0) begin errors++; $display("[TB] FAIL clear_shadow got %0d want 0", if0.rd_data); end
    step(2);
    checks++; if (if0.running !== 1'b0 || if0.done !== 1'b0) begin errors++; $display("[TB] FAIL clear_idle got run=%b done=%b want 0/0", if0.running, if0.done); end
  endtask

  task automatic test_timeout();
    ift.start = 1'b1; step(1); ift.start = 1'b0;
    ift.event_in = 4'b0001;
    step(15);
    checks++; if (ift.cycles_consumed !== 32'd15 || ift.timeout !== 1'b0 || ift.running !== 1'b1) begin errors++; $display("[TB] FAIL pre_timeout got cyc=%0d to=%b run=%b want 15/0/1", ift.cycles_consumed, ift.timeout, ift.running); end
    step(1);
    checks++; if (ift.cycles_consumed !== 32'd16 || ift.timeout !== 1'b1 || ift.done !== 1'b1) begin errors++; $display("[TB] FAIL timeout got cyc=%0d to=%b done=%b want 16/1/1", ift.cycles_consumed, ift.timeout, ift.done); end
    step(5);
    ift.event_in = 4'b0000;
    checks++; if (ift.cycles_consumed !== 32'd16) begin errors++; $display("[TB] FAIL timeout_frozen got %0d want 16", ift.cycles_consumed); end
    ift.snap = 1'b1; step(1); ift.snap = 1'b0;
    ift.rd_sel = 2'd0; step(1);
    checks++; if (ift.rd_data !== 32'd16) begin errors++; $display("[TB] FAIL timeout_channel0 got %0d want 16", ift.rd_data); end
    ift.start = 1'b1; step(1); ift.start = 1'b0;
    checks++; if (ift.timeout !== 1'b0 || ift.cycles_consumed !== 32'd0) begin errors++; $display("[TB] FAIL restart_clears_timeout got to=%b cyc=%0d want 0/0", ift.timeout, ift.cycles_consumed); end
    step(15);
    ift.halt = 1'b1; step(1); ift.halt = 1'b0;
    checks++; if (ift.timeout !== 1'b1 || ift.done !== 1'b1 || ift.cycles_consumed !== 32'd16) begin errors++; $display("[TB] FAIL halt_with_timeout got to=%b done=%b cyc=%0d want 1/1/16", ift.timeout, ift.done, ift.cycles_consumed); end
  endtask

  task automatic test_saturate_wrap();
    ifs.start = 1'b1; ifw.start = 1'b1; step(1); ifs.start = 1'b0; ifw.start = 1'b0;
    ifs.event_in = 3'b001; ifw.event_in = 3'b001;
    step(255);
    checks++; if (ifs.overflow !== 3'b000) begin errors++; $display("[TB] FAIL no_early_overflow got %b want 000", ifs.overflow); end
    step(44);
    ifs.halt = 1'b1; ifw.halt = 1'b1; step(1);
    ifs.halt = 1'b0; ifw.halt = 1'b0; ifs.event_in = 3'b000; ifw.event_in = 3'b000;
    checks++; if (ifs.overflow !== 3'b001 || ifw.overflow !== 3'b001) begin errors++; $display("[TB] FAIL overflow got sat=%b wrap=%b want 001/001", ifs.overflow, ifw.overflow); end
    checks++; if (ifs.cycles_consumed !== 8'd255 || ifw.cycles_consumed !== 8'd44) begin errors++; $display("[TB] FAIL narrow_cycles got sat=%0d wrap=%0d want 255/44", ifs.cycles_consumed, ifw.cycles_consumed); end
    ifs.snap = 1'b1; ifw.snap = 1'b1; step(1); ifs.snap = 1'b0; ifw.snap = 1'b0;
    ifs.rd_sel = 2'd0; ifw.rd_sel = 2'd0; step(1);
    checks++; if (ifs.rd_data !== 8'd255) begin errors++; $display("[TB] FAIL saturate_channel0 got %0d want 255", ifs.rd_data); end
    checks++; if (ifw.rd_data !== 8'd44) begin errors++; $display("[TB] FAIL wrap_channel0 got %0d want 44", ifw.rd_data); end
    ifs.rd_sel = 2'd3; ifw.rd_sel = 2'd3; step(1);
    checks++; if (ifs.rd_data !== 8'd0 || ifw.rd_data !== 8'd0) begin errors++; $display("[TB] FAIL out_of_range_sel got sat=%0d wrap=%0d want 0/0", ifs.rd_data, ifw.rd_data); end
  endtask

  task automatic test_mid_run_reset();
    if0.start = 1'b1; step(1); if0.start = 1'b0;
    if0.event_in = 4'b0001; step(4);
    checks++; if (if0.cycles_consumed !== 32'd4) begin errors++; $display("[TB] FAIL before_reset got %0d want 4", if0.cycles_consumed); end
    #3; rst = 1'b0; #1;
    checks++; if (if0.cycles_consumed !== 32'd0 || if0.running !== 1'b0 || if0.done !== 1'b0) begin errors++; $display("[TB] FAIL async_reset got cyc=%0d run=%b done=%b want 0/0/0", if0.cycles_consumed, if0.running, if0.done); end
    if0.event_in = 4'b0000;
    step(1);
    rst = 1'b1;
    step(2);
    checks++; if (if0.running !== 1'b0 || if0.cycles_consumed !== 32'd0) begin errors++; $display("[TB] FAIL wait_after_reset got run=%b cyc=%0d want 0/0", if0.running, if0.cycles_consumed); end
    if0.start = 1'b1; step(1); if0.start = 1'b0;
    step(2);
    if0.halt = 1'b1; step(1); if0.halt = 1'b0;
    checks++; if (if0.cycles_consumed !== 32'd3 || if0.done !== 1'b1) begin errors++; $display("[TB] FAIL fresh_run got cyc=%0d done=%b want 3/1", if0.cycles_consumed, if0.done); end
    if0.snap = 1'b1; step(1); if0.snap = 1'b0;
    if0.rd_sel = 2'd0; step(1);
    checks++; if (if0.rd_data !== 32'd0) begin errors++; $display("[TB] FAIL discarded_channel0 got %0d want 0", if0.rd_data); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    {if0.start, if0.halt, if0.clear, if0.snap} = 4'b0; if0.event_in = '0; if0.rd_sel = '0;
    {ift.start, ift.halt, ift.clear, ift.snap} = 4'b0; ift.event_in = '0; ift.rd_sel = '0;
    {ifs.start, ifs.halt, ifs.clear, ifs.snap} = 4'b0; ifs.event_in = '0; ifs.rd_sel = '0;
    {ifw.start, ifw.halt, ifw.clear, ifw.snap} = 4'b0; ifw.event_in = '0; ifw.rd_sel = '0;
    test_reset();
    test_basic_run();
    test_events();
    test_snap_same_edge();
    test_clear_halt();
    test_timeout();
    test_saturate_wrap();
    test_mid_run_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
